// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory request path.
// Used by the memory responder and by the CPU-side memory stage.
//   mem_state_t : responder handshake states
//   WORD_BYTES  : bytes per memory word (word index = byte address / 4)
//   mem_req_t   : one request as seen on the CPU data-memory interface
package cpu_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port word storage for the data-memory responder.
//   clk   : write clock
//   we    : write enable, writes wdata to word idx on the rising edge
//   idx   : word index
//   wdata : write data
//   rdata : contents of word idx (value before any write on the same edge)
// Contents are never reset.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory request interface.
// Accepts one load/store at a time, waits WAIT_STATES cycles, then commits
// the access and pulses resp_valid for one cycle.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : CPU presents a request (held until accepted)
//   req_write   : 1 = store, 0 = load
//   req_addr    : byte address
//   req_wdata   : store data
//   req_ready   : request can be accepted this cycle
//   resp_valid  : one-cycle completion pulse
//   resp_rdata  : load data, 0 for stores and errors (held between responses)
//   resp_err    : misaligned or out-of-range access (held between responses)
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(WORD_BYTES);

  mem_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              accept;
  logic              commit;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge itself,
  // before the request has been latched, so the live inputs are used then.
  always_comb begin
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    if (state == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  // Range check done at full address width so addresses above the array
  // never alias onto low words.
  assign c_err  = (c_addr[1:0] != 2'b00) || (64'(c_addr) >= ADDR_LIMIT);
  assign c_idx  = c_addr[IDX_W+1:2];
  assign commit = !rst && (state != RESP) && (state_nx == RESP);
  assign mem_we = commit && c_write && !c_err;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (c_idx),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      resp_valid <= commit;
      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (c_err || c_write) ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

endmodule
